// File: rtl/glitcbus_pkg.sv
// GLITCBUS constants shared by the master and slave ends: FSM state encoding,
// transaction timing and GRDWR_B levels.
package glitcbus_pkg;

   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_SEL  = 4'd1;
   localparam logic [3:0] ST_ADRH = 4'd2;
   localparam logic [3:0] ST_ADRL = 4'd3;
   localparam logic [3:0] ST_TURN = 4'd4;
   localparam logic [3:0] ST_D0   = 4'd5;
   localparam logic [3:0] ST_D1   = 4'd6;
   localparam logic [3:0] ST_D2   = 4'd7;
   localparam logic [3:0] ST_D3   = 4'd8;
   localparam logic [3:0] ST_END  = 4'd9;

   typedef enum logic [3:0] {
      S_IDLE = ST_IDLE,
      S_SEL  = ST_SEL,
      S_ADRH = ST_ADRH,
      S_ADRL = ST_ADRL,
      S_TURN = ST_TURN,
      S_D0   = ST_D0,
      S_D1   = ST_D1,
      S_D2   = ST_D2,
      S_D3   = ST_D3,
      S_END  = ST_END
   } gb_state_e;

   localparam int GB_XFER_CYCLES = 9;
   localparam int GB_TURN_CYCLE  = 3;

   localparam logic GB_RD = 1'b1;
   localparam logic GB_WR = 1'b0;

   // GSEL_B is low in every state from SEL through D3.
   function automatic logic gb_sel_active(input gb_state_e s);
      return (s != S_IDLE) && (s != S_END);
   endfunction

endpackage

// File: rtl/glitcbus_pad.sv
// Eight GAD IOBUFs, each with registered output, output enable and input capture.
module glitcbus_pad
   import glitcbus_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] out_d,
   input  logic [7:0] oe_d,
   output logic [7:0] in_q,
   inout  wire  [7:0] pad_io
);

   logic [7:0] out_q;
   logic [7:0] oe_q;
   logic [7:0] in_d;

   always_comb begin
      in_d = pad_io;
   end

   always_ff @(posedge clk_i) begin
      out_q <= out_d;
      if (rst_i) begin
         oe_q <= '0;
         in_q <= '0;
      end else begin
         oe_q <= oe_d;
         in_q <= in_d;
      end
   end

   for (genvar i = 0; i < 8; i++) begin : g_iobuf
      assign pad_io[i] = oe_q[i] ? out_q[i] : 1'bz;
   end

endmodule

// File: rtl/glitcbus_master.sv
// GLITCBUS initiator: one request -> 9-cycle byte-serial bus transaction.
// Define GLITCBUS_MASTER_DEBUG_EN to drive debug_o; otherwise it is tied to 0.
module glitcbus_master
   import glitcbus_pkg::*;
(
   input  logic        gclk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        wr_i,
   input  logic [15:0] adr_i,
   input  logic [31:0] dat_i,
   output logic        ready_o,
   output logic        done_o,
   output logic [31:0] dat_o,
   output logic        GSEL_B,
   output logic        GRDWR_B,
   inout  wire  [7:0]  GAD,
   output logic [31:0] debug_o
);

   gb_state_e   state_q, state_d;
   logic [3:0]  rcv_q, rcv_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        gsel_q, gsel_d;
   logic        grdwr_q, grdwr_d;
   logic        wr_q, wr_d;
   logic [15:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [23:0] asm_q, asm_d;
   logic [31:0] rdat_q, rdat_d;
   logic [7:0]  gad_out_d;
   logic [7:0]  gad_in;
   logic        gad_oe_d;
   logic        accept;
   logic        busy_d;

   always_comb begin
      accept = req_i && ready_q;
      wr_d   = accept ? wr_i  : wr_q;
      adr_d  = accept ? adr_i : adr_q;
      dat_d  = accept ? dat_i : dat_q;

      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_SEL;
         S_SEL:   state_d = S_ADRH;
         S_ADRH:  state_d = S_ADRL;
         S_ADRL:  state_d = S_TURN;
         S_TURN:  state_d = S_D0;
         S_D0:    state_d = S_D1;
         S_D1:    state_d = S_D2;
         S_D2:    state_d = S_D3;
         S_D3:    state_d = S_END;
         S_END:   state_d = accept ? S_SEL : S_IDLE;
         default: state_d = S_IDLE;
      endcase

      rcv_d   = (rcv_q != 4'd0) ? rcv_q - 4'd1 : 4'd0;
      ready_d = ((state_d == S_IDLE) || (state_d == S_END)) && (rcv_d == 4'd0);

      // Pin flops are loaded from the next state so the pins change on the c-boundaries.
      busy_d    = gb_sel_active(state_d);
      gsel_d    = !busy_d;
      grdwr_d   = busy_d ? (wr_d ? GB_WR : GB_RD) : 1'b1;
      gad_oe_d  = 1'b0;
      gad_out_d = 8'hFF;
      case (state_d)
         S_ADRH:  begin gad_oe_d = 1'b1; gad_out_d = adr_d[15:8];  end
         S_ADRL:  begin gad_oe_d = 1'b1; gad_out_d = adr_d[7:0];   end
         S_D0:    begin gad_oe_d = wr_d; gad_out_d = dat_d[31:24]; end
         S_D1:    begin gad_oe_d = wr_d; gad_out_d = dat_d[23:16]; end
         S_D2:    begin gad_oe_d = wr_d; gad_out_d = dat_d[15:8];  end
         S_D3:    begin gad_oe_d = wr_d; gad_out_d = dat_d[7:0];   end
         default: ;
      endcase

      // A read byte reaches gad_in one cycle after the slave drove it.
      asm_d = asm_q;
      if ((state_q == S_D1) || (state_q == S_D2) || (state_q == S_D3)) begin
         asm_d = {asm_q[15:0], gad_in};
      end
      rdat_d = ((state_q == S_END) && !wr_q) ? {asm_q, gad_in} : rdat_q;
      done_d = ((state_q == S_D3) && wr_q) || ((state_q == S_END) && !wr_q);
   end

   always_ff @(posedge gclk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         rcv_q   <= 4'(GB_XFER_CYCLES);
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         gsel_q  <= 1'b1;
         grdwr_q <= 1'b1;
         adr_q   <= '0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         rcv_q   <= rcv_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         gsel_q  <= gsel_d;
         grdwr_q <= grdwr_d;
         adr_q   <= adr_d;
         rdat_q  <= rdat_d;
      end
   end

   always_ff @(posedge gclk_i) begin
      wr_q  <= wr_d;
      dat_q <= dat_d;
      asm_q <= asm_d;
   end

   glitcbus_pad u_pad (
      .clk_i  (gclk_i),
      .rst_i  (rst_i),
      .out_d  (gad_out_d),
      .oe_d   ({8{gad_oe_d}}),
      .in_q   (gad_in),
      .pad_io (GAD)
   );

   assign ready_o = ready_q;
   assign done_o  = done_q;
   assign dat_o   = rdat_q;
   assign GSEL_B  = gsel_q;
   assign GRDWR_B = grdwr_q;

`ifdef GLITCBUS_MASTER_DEBUG_EN
   logic gad_oe_q;

   always_ff @(posedge gclk_i) begin
      if (rst_i) gad_oe_q <= 1'b0;
      else       gad_oe_q <= gad_oe_d;
   end

   assign debug_o = {adr_q, done_q, gad_oe_q, grdwr_q, gsel_q, gad_in, state_q};
`else
   assign debug_o = '0;
`endif

endmodule

// File: tb/tb_glitcbus_master.sv
// Directed bench for glitcbus_master with a byte-serial slave model on GAD.
module tb_glitcbus_master;
   import glitcbus_pkg::*;

   logic        gclk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        wr_i = 1'b0;
   logic [15:0] adr_i = '0;
   logic [31:0] dat_i = '0;
   logic        ready_o, done_o, GSEL_B, GRDWR_B;
   logic [31:0] dat_o, debug_o;
   wire  [7:0]  GAD;
   logic        slv_oe = 1'b0;
   logic [7:0]  slv_drv = 8'h00;

   int checks = 0;
   int failures = 0;

   logic        rec_gsel [0:20];
   logic        rec_rdwr [0:20];
   logic        rec_done [0:20];
   logic [7:0]  rec_gad  [0:20];
   logic [31:0] rec_dat  [0:20];
   logic [31:0] rec_dbg  [0:20];

   assign GAD = slv_oe ? slv_drv : 8'hzz;

   always #5 gclk = ~gclk;

   glitcbus_master dut (
      .gclk_i  (gclk),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .wr_i    (wr_i),
      .adr_i   (adr_i),
      .dat_i   (dat_i),
      .ready_o (ready_o),
      .done_o  (done_o),
      .dat_o   (dat_o),
      .GSEL_B  (GSEL_B),
      .GRDWR_B (GRDWR_B),
      .GAD     (GAD),
      .debug_o (debug_o)
   );

   task automatic sample(input int c);
      rec_gsel[c] = GSEL_B;
      rec_rdwr[c] = GRDWR_B;
      rec_done[c] = done_o;
      rec_gad[c]  = GAD;
      rec_dat[c]  = dat_o;
      rec_dbg[c]  = debug_o;
   endtask

   // Issue one request in the current (ready) cycle and record c0..c10.
   // The slave drives 00 in c0, turnaround and c8 so any master drive there corrupts GAD.
   task automatic run_txn(input logic w, input logic [15:0] a, input logic [31:0] d,
                          input logic [31:0] rb, input bit tog);
      req_i = 1'b1; wr_i = w; adr_i = a; dat_i = d;
      for (int c = 0; c <= 10; c++) begin
         @(posedge gclk); #1;
         if (c == 0) req_i = 1'b0;
         slv_oe = 1'b0; slv_drv = 8'h00;
         if (c == 0 || c == GB_TURN_CYCLE || c == GB_XFER_CYCLES - 1) slv_oe = 1'b1;
         if (!w && c >= 4 && c <= 7) begin
            slv_oe = 1'b1;
            slv_drv = rb[8*(7-c) +: 8];
         end
         if (tog && c >= 1 && c <= 7) begin
            adr_i = ~adr_i; dat_i = ~dat_i; wr_i = ~wr_i;
         end
         #1; sample(c);
      end
      slv_oe = 1'b0;
   endtask

   task automatic test_reset;
      rst_i = 1'b1; req_i = 1'b0;
      @(posedge gclk); @(posedge gclk); #1;
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", ready_o); end
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done_o); end
      checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got %h want 0", dat_o); end
      checks++; if (GSEL_B !== 1'b1) begin failures++; $display("FAIL reset_gsel got %b want 1", GSEL_B); end
      checks++; if (GRDWR_B !== 1'b1) begin failures++; $display("FAIL reset_grdwr got %b want 1", GRDWR_B); end
`ifdef GLITCBUS_MASTER_DEBUG_EN
      checks++; if (debug_o !== 32'h0000_3000) begin failures++; $display("FAIL reset_debug got %h want 00003000", debug_o); end
`else
      checks++; if (debug_o !== 32'h0) begin failures++; $display("FAIL reset_debug got %h want 0", debug_o); end
`endif
      rst_i = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge gclk); #1;
         checks++;
         if (ready_o !== (k >= 9)) begin
            failures++; $display("FAIL reset_recovery k%0d ready got %b want %b", k, ready_o, (k >= 9));
         end
      end
   endtask

   task automatic test_write;
      logic [7:0] eg [0:8];
      eg = '{8'h00, 8'h12, 8'h34, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
      run_txn(1'b1, 16'h1234, 32'hDEADBEEF, 32'h0, 1'b0);
      for (int c = 0; c <= 10; c++) begin
         checks++;
         if (rec_done[c] !== (c == 8)) begin
            failures++; $display("FAIL write_done c%0d got %b want %b", c, rec_done[c], (c == 8));
         end
      end
      for (int c = 0; c <= 8; c++) begin
         checks++;
         if (rec_gad[c] !== eg[c]) begin
            failures++; $display("FAIL write_gad c%0d got %h want %h", c, rec_gad[c], eg[c]);
         end
         checks++;
         if (rec_gsel[c] !== (c == 8)) begin
            failures++; $display("FAIL write_gsel c%0d got %b want %b", c, rec_gsel[c], (c == 8));
         end
         checks++;
         if (rec_rdwr[c] !== (c == 8)) begin
            failures++; $display("FAIL write_grdwr c%0d got %b want %b", c, rec_rdwr[c], (c == 8));
         end
`ifdef GLITCBUS_MASTER_DEBUG_EN
         checks++;
         if (rec_dbg[c][31:16] !== 16'h1234) begin
            failures++; $display("FAIL write_debug_adr c%0d got %h want 1234", c, rec_dbg[c][31:16]);
         end
`else
         checks++;
         if (rec_dbg[c] !== 32'h0) begin
            failures++; $display("FAIL write_debug c%0d got %h want 0", c, rec_dbg[c]);
         end
`endif
      end
   endtask

   task automatic test_read;
      logic [7:0] eg [0:8];
      eg = '{8'h00, 8'hA5, 8'h5A, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
      run_txn(1'b0, 16'hA55A, 32'hFFFFFFFF, 32'h01234567, 1'b0);
      for (int c = 0; c <= 10; c++) begin
         checks++;
         if (rec_done[c] !== (c == 9)) begin
            failures++; $display("FAIL read_done c%0d got %b want %b", c, rec_done[c], (c == 9));
         end
      end
      for (int c = 0; c <= 8; c++) begin
         checks++;
         if (rec_gad[c] !== eg[c]) begin
            failures++; $display("FAIL read_gad c%0d got %h want %h", c, rec_gad[c], eg[c]);
         end
         checks++;
         if (rec_rdwr[c] !== 1'b1) begin
            failures++; $display("FAIL read_grdwr c%0d got %b want 1", c, rec_rdwr[c]);
         end
      end
      checks++; if (rec_dat[8] !== 32'h0) begin failures++; $display("FAIL read_dat_early got %h want 00000000", rec_dat[8]); end
      checks++; if (rec_dat[9] !== 32'h01234567) begin failures++; $display("FAIL read_dat got %h want 01234567", rec_dat[9]); end
      checks++; if (rec_dat[10] !== 32'h01234567) begin failures++; $display("FAIL read_dat_hold got %h want 01234567", rec_dat[10]); end
   endtask

   task automatic test_input_hold;
      logic [7:0] eg [0:8];
      eg = '{8'h00, 8'hC0, 8'hDE, 8'h00, 8'h13, 8'h57, 8'h9B, 8'hDF, 8'h00};
      run_txn(1'b1, 16'hC0DE, 32'h13579BDF, 32'h0, 1'b1);
      for (int c = 0; c <= 8; c++) begin
         checks++;
         if (rec_gad[c] !== eg[c]) begin
            failures++; $display("FAIL hold_gad c%0d got %h want %h", c, rec_gad[c], eg[c]);
         end
         checks++;
         if (rec_rdwr[c] !== (c == 8)) begin
            failures++; $display("FAIL hold_grdwr c%0d got %b want %b", c, rec_rdwr[c], (c == 8));
         end
      end
      checks++; if (rec_done[8] !== 1'b1) begin failures++; $display("FAIL hold_done got %b want 1", rec_done[8]); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rb;
      int f2;
      int highs;
      rb = 32'h89ABCDEF;
      req_i = 1'b1; wr_i = 1'b1; adr_i = 16'h0F0F; dat_i = 32'hCAFEF00D;
      for (int c = 0; c <= 19; c++) begin
         @(posedge gclk); #1;
         if (c == 0) begin wr_i = 1'b0; adr_i = 16'h5AA5; dat_i = 32'h0; end
         if (c == 9) req_i = 1'b0;
         slv_oe = 1'b0; slv_drv = 8'h00;
         if (c >= 13 && c <= 16) begin slv_oe = 1'b1; slv_drv = rb[8*(16-c) +: 8]; end
         #1; sample(c);
      end
      slv_oe = 1'b0;
      f2 = -1; highs = 0;
      for (int c = 1; c <= 19; c++) begin
         if (f2 < 0 && rec_gsel[c-1] === 1'b1 && rec_gsel[c] === 1'b0) f2 = c;
      end
      for (int c = 0; c <= 16; c++) if (rec_gsel[c] === 1'b1) highs++;
      checks++; if (rec_gsel[0] !== 1'b0) begin failures++; $display("FAIL b2b_first_sel got %b want 0", rec_gsel[0]); end
      checks++; if (f2 != 9) begin failures++; $display("FAIL b2b_second_fall got %0d want 9", f2); end
      checks++; if (highs != 1) begin failures++; $display("FAIL b2b_gsel_high_cycles got %0d want 1", highs); end
      checks++; if (rec_rdwr[7] !== 1'b0) begin failures++; $display("FAIL b2b_wr_grdwr got %b want 0", rec_rdwr[7]); end
      checks++; if (rec_rdwr[9] !== 1'b1) begin failures++; $display("FAIL b2b_rd_grdwr got %b want 1", rec_rdwr[9]); end
      checks++; if (rec_gad[1] !== 8'h0F) begin failures++; $display("FAIL b2b_wr_adrh got %h want 0f", rec_gad[1]); end
      checks++; if (rec_gad[10] !== 8'h5A) begin failures++; $display("FAIL b2b_rd_adrh got %h want 5a", rec_gad[10]); end
      checks++; if (rec_gad[11] !== 8'hA5) begin failures++; $display("FAIL b2b_rd_adrl got %h want a5", rec_gad[11]); end
      for (int c = 0; c <= 19; c++) begin
         checks++;
         if (rec_done[c] !== (c == 8 || c == 18)) begin
            failures++; $display("FAIL b2b_done c%0d got %b want %b", c, rec_done[c], (c == 8 || c == 18));
         end
      end
      checks++; if (rec_dat[18] !== 32'h89ABCDEF) begin failures++; $display("FAIL b2b_rd_dat got %h want 89abcdef", rec_dat[18]); end
   endtask

   task automatic test_reset_mid;
      req_i = 1'b1; wr_i = 1'b1; adr_i = 16'h3C3C; dat_i = 32'h11223344;
      for (int c = 0; c <= 5; c++) begin
         @(posedge gclk); #1;
         if (c == 0) req_i = 1'b0;
      end
      rst_i = 1'b1;
      @(posedge gclk); #1;
      rst_i = 1'b0;
      checks++; if (GSEL_B !== 1'b1) begin failures++; $display("FAIL midrst_gsel got %b want 1", GSEL_B); end
      checks++; if (GRDWR_B !== 1'b1) begin failures++; $display("FAIL midrst_grdwr got %b want 1", GRDWR_B); end
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL midrst_done got %b want 0", done_o); end
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL midrst_ready got %b want 0", ready_o); end
      for (int k = 1; k <= 9; k++) begin
         @(posedge gclk); #1;
         checks++;
         if (ready_o !== (k >= 9)) begin
            failures++; $display("FAIL midrst_recovery k%0d ready got %b want %b", k, ready_o, (k >= 9));
         end
         checks++;
         if (done_o !== 1'b0 || GSEL_B !== 1'b1) begin
            failures++; $display("FAIL midrst_quiet k%0d done got %b gsel got %b want 0/1", k, done_o, GSEL_B);
         end
      end
      run_txn(1'b0, 16'h7777, 32'h0, 32'hFEDCBA98, 1'b0);
      checks++; if (rec_done[9] !== 1'b1) begin failures++; $display("FAIL midrst_rd_done got %b want 1", rec_done[9]); end
      checks++; if (rec_dat[9] !== 32'hFEDCBA98) begin failures++; $display("FAIL midrst_rd_dat got %h want fedcba98", rec_dat[9]); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_input_hold();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
